// File: rtl/circuit_vector_checker.sv
// rtl/circuit_vector_checker.sv - sweeps all 8 x/y/z vectors and checks op = (~x & z) | y
module circuit_vector_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             x,
  output logic             y,
  output logic             z,
  input  logic             op,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [2:0]       first_fail_vec,
  output logic             first_fail_valid
);

  localparam int CW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [CW-1:0]    SETTLE_LOAD = CW'(SETTLE_CYCLES);
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [2:0]      vec_idx;
  logic [CW-1:0]   settle_cnt;
  logic            exp_op;
  logic            mismatch;

  // Golden response from the registered stimulus, not from vec_idx
  assign exp_op   = (~x & z) | y;
  assign mismatch = (state == SAMPLE) && (op != exp_op);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  // State register; reset aborts any sweep without a done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; start is only looked at in IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    state_nxt = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
      SETTLE:  if (settle_cnt <= CW'(1)) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = (vec_idx == 3'd7) ? DONE : LOAD;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stimulus, settle counter and result bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x                <= 1'b0;
      y                <= 1'b0;
      z                <= 1'b0;
      vec_idx          <= 3'd0;
      settle_cnt       <= '0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail_vec   <= 3'd0;
      first_fail_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            vec_idx          <= 3'd0;
            err_count        <= '0;
            pass             <= 1'b0;
            first_fail_valid <= 1'b0;
          end
        end
        LOAD: begin
          {x, y, z}  <= vec_idx;
          settle_cnt <= SETTLE_LOAD;
        end
        SETTLE: begin
          settle_cnt <= settle_cnt - CW'(1);
        end
        SAMPLE: begin
          if (mismatch) begin
            if (err_count != ERR_MAX) err_count <= err_count + ERR_W'(1);
            if (!first_fail_valid) begin
              first_fail_vec   <= vec_idx;
              first_fail_valid <= 1'b1;
            end
          end
          // first_fail_valid is the sticky mismatch flag, so pass survives err_count saturation
          if (vec_idx == 3'd7) begin
            pass <= !(first_fail_valid || mismatch);
          end else begin
            vec_idx <= vec_idx + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
